// File: rtl/ts_sync_aligner.sv
// MPEG-TS sync hunter/aligner: locks onto 0x47 at PACKET_SIZE spacing and emits whole packets.
// Optional `TS_SYNC_ERR_FLAG_EN: repairs flywheel sync bytes and sets transport_error_indicator.
module ts_sync_aligner #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int PACKET_SIZE        = 188,
    parameter int LOCK_COUNT         = 3,
    parameter int LOSS_COUNT         = 3
) (
    input  logic                          mpeg_clk,
    input  logic                          rst_n,
    input  logic [7:0]                    mpeg_data,
    input  logic                          mpeg_valid,
    input  logic                          stats_clear,
    output logic [7:0]                    ts_out,
    output logic                          ts_out_valid,
    output logic                          ts_out_sync,
    output logic                          locked,
    output logic [C_S_AXI_DATA_WIDTH-1:0] packet_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] sync_loss_count
);

    localparam int BW = $clog2(PACKET_SIZE);
    localparam int HW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(PACKET_SIZE - 1);
    localparam logic [HW-1:0] LOCK_V    = HW'(LOCK_COUNT);
    localparam logic [MW-1:0] LOSS_V    = MW'(LOSS_COUNT);
    localparam logic [7:0]    SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                        r_state;
    logic   [BW-1:0]               r_byte_cnt;
    logic   [HW-1:0]               r_hit_cnt;
    logic   [MW-1:0]               r_miss_cnt;
    logic   [7:0]                  r_ts_out;
    logic                          r_ts_out_valid;
    logic                          r_ts_out_sync;
    logic   [C_S_AXI_DATA_WIDTH-1:0] r_packet_count;
    logic   [C_S_AXI_DATA_WIDTH-1:0] r_sync_loss_count;

    state_t                        w_state_nxt;
    logic   [BW-1:0]               w_byte_cnt_nxt;
    logic   [HW-1:0]               w_hit_cnt_nxt;
    logic   [MW-1:0]               w_miss_cnt_nxt;
    logic   [BW-1:0]               w_byte_inc;
    logic   [HW-1:0]               w_hit_inc;
    logic   [MW-1:0]               w_miss_inc;
    logic                          w_at_sync;
    logic                          w_is_sync;
    logic                          w_emit;
    logic                          w_flywheel;
    logic                          w_loss;
    logic   [7:0]                  w_out_byte;

    assign w_at_sync  = (r_byte_cnt == '0);
    assign w_is_sync  = (mpeg_data == SYNC_BYTE);
    assign w_byte_inc = (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + BW'(1);
    assign w_hit_inc  = r_hit_cnt + HW'(1);
    assign w_miss_inc = r_miss_cnt + MW'(1);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_hit_cnt_nxt  = r_hit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
        w_emit         = 1'b0;
        w_flywheel     = 1'b0;
        w_loss         = 1'b0;
        if (mpeg_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_is_sync) begin
                        w_state_nxt    = ST_VERIFY;
                        w_byte_cnt_nxt = BW'(1);
                        w_hit_cnt_nxt  = HW'(1);
                    end
                end
                ST_VERIFY: begin
                    w_byte_cnt_nxt = w_byte_inc;
                    if (w_at_sync) begin
                        if (w_is_sync) begin
                            w_hit_cnt_nxt = w_hit_inc;
                            if (w_hit_inc == LOCK_V) begin
                                w_state_nxt    = ST_LOCKED;
                                w_miss_cnt_nxt = '0;
                                w_emit         = 1'b1;
                            end
                        end else begin
                            w_state_nxt    = ST_HUNT;
                            w_hit_cnt_nxt  = '0;
                            w_byte_cnt_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_emit         = 1'b1;
                    w_byte_cnt_nxt = w_byte_inc;
                    if (w_at_sync && w_is_sync) begin
                        w_miss_cnt_nxt = '0;
                    end else if (w_at_sync) begin
                        if (w_miss_inc == LOSS_V) begin
                            // Lock lost: the bad sync byte is dropped, not emitted.
                            w_state_nxt    = ST_HUNT;
                            w_emit         = 1'b0;
                            w_loss         = 1'b1;
                            w_byte_cnt_nxt = '0;
                            w_hit_cnt_nxt  = '0;
                            w_miss_cnt_nxt = '0;
                        end else begin
                            w_miss_cnt_nxt = w_miss_inc;
                            w_flywheel     = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt    = ST_HUNT;
                    w_byte_cnt_nxt = '0;
                    w_hit_cnt_nxt  = '0;
                    w_miss_cnt_nxt = '0;
                end
            endcase
        end
    end

`ifdef TS_SYNC_ERR_FLAG_EN
    logic r_err_flag;

    always_ff @(posedge mpeg_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_flag <= 1'b0;
        end else if (mpeg_valid) begin
            r_err_flag <= w_flywheel;
        end
    end

    // Byte 1 of a flywheel packet follows on the very next valid byte.
    always_comb begin
        w_out_byte = mpeg_data;
        if (w_flywheel) begin
            w_out_byte = SYNC_BYTE;
        end else if (r_err_flag && w_emit) begin
            w_out_byte = mpeg_data | 8'h80;
        end
    end
`else
    assign w_out_byte = mpeg_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge mpeg_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_HUNT;
            r_byte_cnt        <= '0;
            r_hit_cnt         <= '0;
            r_miss_cnt        <= '0;
            r_ts_out          <= '0;
            r_ts_out_valid    <= 1'b0;
            r_ts_out_sync     <= 1'b0;
            r_packet_count    <= '0;
            r_sync_loss_count <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_byte_cnt     <= w_byte_cnt_nxt;
            r_hit_cnt      <= w_hit_cnt_nxt;
            r_miss_cnt     <= w_miss_cnt_nxt;
            r_ts_out_valid <= w_emit;
            r_ts_out_sync  <= w_emit && w_at_sync;
            if (mpeg_valid) begin
                r_ts_out <= w_out_byte;
            end
            if (stats_clear) begin
                r_packet_count    <= '0;
                r_sync_loss_count <= '0;
            end else begin
                if (w_emit && w_at_sync) begin
                    r_packet_count <= r_packet_count + 1'b1;
                end
                if (w_loss) begin
                    r_sync_loss_count <= r_sync_loss_count + 1'b1;
                end
            end
        end
    end

    assign ts_out          = r_ts_out;
    assign ts_out_valid    = r_ts_out_valid;
    assign ts_out_sync     = r_ts_out_sync;
    assign locked          = (r_state == ST_LOCKED);
    assign packet_count    = r_packet_count;
    assign sync_loss_count = r_sync_loss_count;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Randomized self-checking bench for ts_sync_aligner against a byte-stream reference model.
// Model follows TS_SYNC_ERR_FLAG_EN when the same macro is defined for the bench.
module tb_ts_sync_aligner;

    localparam int PS    = 188;
    localparam int LOCKN = 3;
    localparam int LOSSN = 3;
    localparam int W     = 32;

    logic         mpeg_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   mpeg_data = 8'h00;
    logic         mpeg_valid = 1'b0;
    logic         stats_clear = 1'b0;
    logic [7:0]   ts_out;
    logic         ts_out_valid;
    logic         ts_out_sync;
    logic         locked;
    logic [W-1:0] packet_count;
    logic [W-1:0] sync_loss_count;

    ts_sync_aligner #(
        .C_S_AXI_DATA_WIDTH(W),
        .PACKET_SIZE(PS),
        .LOCK_COUNT(LOCKN),
        .LOSS_COUNT(LOSSN)
    ) dut (
        .mpeg_clk(mpeg_clk),
        .rst_n(rst_n),
        .mpeg_data(mpeg_data),
        .mpeg_valid(mpeg_valid),
        .stats_clear(stats_clear),
        .ts_out(ts_out),
        .ts_out_valid(ts_out_valid),
        .ts_out_sync(ts_out_sync),
        .locked(locked),
        .packet_count(packet_count),
        .sync_loss_count(sync_loss_count)
    );

    always #5 mpeg_clk = ~mpeg_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: positions derive from the count of valid bytes since the candidate sync.
    typedef enum int {M_HUNT, M_VERIFY, M_LOCKED} mode_t;
    mode_t        m_mode;
    int           m_n, m_anchor, m_hits, m_miss;
    bit           m_fly;
    logic [31:0]  m_pkts, m_losses;
    bit           e_valid, e_sync;
    logic [7:0]   e_data;

    // Bench-side observation of sync spacing
    int vidx, first_sync, last_sync;

    function automatic void model_reset();
        m_mode = M_HUNT; m_n = 0; m_anchor = 0; m_hits = 0; m_miss = 0; m_fly = 0;
        m_pkts = 0; m_losses = 0; e_valid = 0; e_sync = 0; e_data = 0;
        vidx = 0; first_sync = -1; last_sync = -1;
    endfunction

    function automatic void model_step(input logic [7:0] d, input bit v, input bit c);
        int  pos;
        bit  emit, fly, was_fly;
        emit = 0; fly = 0;
        e_valid = 0; e_sync = 0;
        if (v) begin
            pos = (m_n - m_anchor) % PS;
            case (m_mode)
                M_HUNT: if (d == 8'h47) begin
                    m_mode = M_VERIFY; m_anchor = m_n; m_hits = 1;
                end
                M_VERIFY: if (pos == 0) begin
                    if (d == 8'h47) begin
                        m_hits++;
                        if (m_hits == LOCKN) begin m_mode = M_LOCKED; m_miss = 0; emit = 1; end
                    end else begin
                        m_mode = M_HUNT; m_hits = 0;
                    end
                end
                default: begin
                    if (pos == 0 && d != 8'h47) begin
                        if (m_miss + 1 == LOSSN) begin
                            m_mode = M_HUNT; m_hits = 0; m_miss = 0; m_losses++;
                        end else begin
                            m_miss++; emit = 1; fly = 1;
                        end
                    end else begin
                        if (pos == 0) m_miss = 0;
                        emit = 1;
                    end
                end
            endcase
            was_fly = m_fly;
            m_fly = fly;
            e_data = d;
`ifdef TS_SYNC_ERR_FLAG_EN
            if (fly) e_data = 8'h47;
            else if (was_fly && emit) e_data = d | 8'h80;
`endif
            if (emit) begin
                e_valid = 1;
                e_sync = (pos == 0);
                if (pos == 0) m_pkts++;
            end
            m_n++;
        end
        if (c) begin m_pkts = 0; m_losses = 0; end
    endfunction

    task automatic compare_outputs();
        check("valid", {31'b0, ts_out_valid}, {31'b0, e_valid});
        if (e_valid) begin
            check("data", {24'b0, ts_out}, {24'b0, e_data});
            check("sync", {31'b0, ts_out_sync}, {31'b0, e_sync});
        end
        check("locked", {31'b0, locked}, {31'b0, m_mode == M_LOCKED});
        check("pkt_cnt", packet_count, m_pkts);
        check("loss_cnt", sync_loss_count, m_losses);
    endtask

    task automatic cycle(input logic [7:0] d, input bit v, input bit c);
        mpeg_data = d; mpeg_valid = v; stats_clear = c;
        @(posedge mpeg_clk); #1;
        model_step(d, v, c);
        compare_outputs();
        if (v) vidx++;
        if (!locked) last_sync = -1;
        if (ts_out_sync) begin
            if (first_sync < 0) first_sync = vidx - 1;
            if (last_sync >= 0) check("sync_period", vidx - 1 - last_sync, PS);
            last_sync = vidx - 1;
        end
    endtask

    function automatic logic [7:0] rnd_no_sync();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h47) b = 8'h46;
        return b;
    endfunction

    // gap: 0 = none, 1 = invalid cycle after every byte, 2 = random gaps
    task automatic send_pkt(input logic [7:0] b0, input bit clean, input int gap, input int nbytes);
        logic [7:0] d;
        for (int i = 0; i < nbytes; i++) begin
            d = (i == 0) ? b0 : (clean ? 8'h00 : rnd_no_sync());
            cycle(d, 1'b1, 1'b0);
            if (gap == 1) cycle(8'($urandom), 1'b0, 1'b0);
            else if (gap == 2 && $urandom_range(3, 0) == 0) cycle(8'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mpeg_valid = 1'b0; stats_clear = 1'b0;
        #2;
        check("rst_ts_out", {24'b0, ts_out}, 32'h0);
        check("rst_valid", {31'b0, ts_out_valid}, 32'h0);
        check("rst_sync", {31'b0, ts_out_sync}, 32'h0);
        check("rst_locked", {31'b0, locked}, 32'h0);
        check("rst_pkt", packet_count, 32'h0);
        check("rst_loss", sync_loss_count, 32'h0);
        model_reset();
        @(posedge mpeg_clk); #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] pk_before;

    initial begin
        model_reset();
        @(posedge mpeg_clk); #1;
        do_reset();

        // 1: four clean packets
        for (int p = 0; p < 4; p++) send_pkt(8'h47, 1'b1, 0, PS);
        check("s1_locked", {31'b0, locked}, 32'h1);
        check("s1_first_sync", first_sync, 2 * PS);
        check("s1_pkts", packet_count, 32'd2);

        // 2: junk then random-payload packets
        do_reset();
        for (int i = 0; i < 37; i++) cycle(rnd_no_sync(), 1'b1, 1'b0);
        for (int p = 0; p < 5; p++) send_pkt(8'h47, 1'b0, 0, PS);
        check("s2_first_sync", first_sync, 37 + 2 * PS);
        check("s2_pkts", packet_count, 32'd3);

        // 3: false sync at 50, real phase at 100
        do_reset();
        for (int i = 0; i < 50; i++) cycle(rnd_no_sync(), 1'b1, 1'b0);
        cycle(8'h47, 1'b1, 1'b0);
        for (int i = 51; i < 100; i++) cycle(rnd_no_sync(), 1'b1, 1'b0);
        for (int p = 0; p < 6; p++) send_pkt(8'h47, 1'b0, 0, PS);
        check("s3_first_sync", first_sync, 100 + 3 * PS);
        check("s3_locked", {31'b0, locked}, 32'h1);

        // 4: two flywheel packets then a good one
        pk_before = packet_count;
        send_pkt(8'h00, 1'b0, 0, PS);
        send_pkt(8'h00, 1'b0, 0, PS);
        send_pkt(8'h47, 1'b0, 0, PS);
        check("s4_locked", {31'b0, locked}, 32'h1);
        check("s4_pkts", packet_count - pk_before, 32'd3);

        // 5: three bad sync bytes -> loss, then stats_clear
        send_pkt(8'h12, 1'b0, 0, PS);
        send_pkt(8'h34, 1'b0, 0, PS);
        send_pkt(8'h56, 1'b0, 0, 1);
        check("s5_unlocked", {31'b0, locked}, 32'h0);
        check("s5_loss", sync_loss_count, 32'd1);
        send_pkt(8'h00, 1'b0, 0, PS - 1);
        cycle(8'h00, 1'b0, 1'b1);
        check("s5_clr_pkt", packet_count, 32'h0);
        check("s5_clr_loss", sync_loss_count, 32'h0);

        // 6: toggling valid, reset mid-packet, fresh relock
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(8'h47, 1'b0, 1, PS);
        send_pkt(8'h47, 1'b0, 1, 90);
        check("s6_locked_pre", {31'b0, locked}, 32'h1);
        do_reset();
        for (int p = 0; p < 2; p++) send_pkt(8'h47, 1'b0, 1, PS);
        check("s6_not_yet", {31'b0, locked}, 32'h0);
        send_pkt(8'h47, 1'b0, 1, 1);
        check("s6_relock", {31'b0, locked}, 32'h1);

        // 7: randomized mix of gaps, bad syncs, arbitrary payload and clears
        do_reset();
        for (int p = 0; p < 24; p++) begin
            for (int i = 0; i < PS; i++) begin
                logic [7:0] d;
                if (i == 0) d = ($urandom_range(99, 0) < 80) ? 8'h47 : rnd_no_sync();
                else d = 8'($urandom);
                cycle(d, 1'b1, ($urandom_range(499, 0) == 0));
                if ($urandom_range(3, 0) == 0) cycle(8'($urandom), 1'b0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
